// File: rtl/lsu_mem_ctrl_if.sv
// Handshake and memory-port bundle between the MEM-stage pipeline, the LSU and the data memory.
// master = pipeline plus memory side, slave = lsu_mem_ctrl.
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_r_enable;
  logic              mem_w_enable;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_wr_data;
  logic [31:0]       mem_re_data;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_re_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_r_enable, mem_w_enable, mem_address, mem_wr_data
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_re_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_r_enable, mem_w_enable, mem_address, mem_wr_data
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32I MEM-stage load/store controller for a word-wide synchronous-read memory; sub-word stores use read-modify-write.
// Optional macro LSU_RANGE_CHK_EN: addresses beyond the memory flag resp_err instead of aliasing.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    RMW_WR  = 2'd2
  } state_t;

  state_t            state_r;
  logic [2:0]        funct3_r;
  logic [1:0]        offset_r;
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       wdata_r;
  logic              resp_valid_r;
  logic              resp_err_r;
  logic [31:0]       resp_rdata_r;

  logic              accept_s;
  logic              err_s;
  logic              sub_store_s;
  logic              mem_r_enable_s;
  logic              mem_w_enable_s;
  logic [ADDR_W-1:0] mem_address_s;
  logic [31:0]       mem_wr_data_s;

  function automatic logic req_illegal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic bad;
    case (f3)
      3'b000:         bad = 1'b0;
      3'b001:         bad = addr[0];
      3'b010:         bad = addr[1] | addr[0];
      3'b100, 3'b101: bad = we | (f3[0] & addr[0]);
      default:        bad = 1'b1;
    endcase
`ifdef LSU_RANGE_CHK_EN
    bad = bad | (addr[31:ADDR_W+2] != {(30-ADDR_W){1'b0}});
`endif
    return bad;
  endfunction

  function automatic logic [31:0] load_format(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rmw_merge(input logic [31:0] old, input logic [15:0] wd,
                                            input logic half, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    if (half) begin
      if (off[1]) r[31:16] = wd;
      else        r[15:0]  = wd;
    end else begin
      case (off)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        2'd3:    r[31:24] = wd[7:0];
        default: r[7:0]   = wd[7:0];
      endcase
    end
    return r;
  endfunction

  // Request decode and memory-port drive; rst_n gating keeps the memory quiet during reset.
  always_comb begin
    accept_s       = bus.req_valid & (state_r == IDLE) & rst_n;
    err_s          = req_illegal(bus.req_we, bus.req_funct3, bus.req_addr);
    sub_store_s    = bus.req_we & (bus.req_funct3 != 3'b010);
    mem_r_enable_s = 1'b0;
    mem_w_enable_s = 1'b0;
    mem_address_s  = {ADDR_W{1'b0}};
    mem_wr_data_s  = 32'd0;
    if (state_r == RMW_WR) begin
      mem_w_enable_s = 1'b1;
      mem_address_s  = addr_r;
      mem_wr_data_s  = rmw_merge(bus.mem_re_data, wdata_r, funct3_r[0], offset_r);
    end else if (accept_s && !err_s) begin
      mem_address_s = bus.req_addr[ADDR_W+1:2];
      if (bus.req_we && !sub_store_s) begin
        mem_w_enable_s = 1'b1;
        mem_wr_data_s  = bus.req_wdata;
      end else begin
        mem_r_enable_s = 1'b1;
      end
    end else begin
      mem_r_enable_s = 1'b0;
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      funct3_r     <= 3'd0;
      offset_r     <= 2'd0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= 16'd0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'd0;
    end else begin
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (err_s) begin
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
            end else if (!bus.req_we) begin
              funct3_r <= bus.req_funct3;
              offset_r <= bus.req_addr[1:0];
              state_r  <= LD_WAIT;
            end else if (sub_store_s) begin
              funct3_r <= bus.req_funct3;
              offset_r <= bus.req_addr[1:0];
              addr_r   <= bus.req_addr[ADDR_W+1:2];
              wdata_r  <= bus.req_wdata[15:0];
              state_r  <= RMW_WR;
            end else begin
              resp_valid_r <= 1'b1;
            end
          end
        end
        LD_WAIT: begin
          resp_valid_r <= 1'b1;
          resp_rdata_r <= load_format(bus.mem_re_data, funct3_r, offset_r);
          state_r      <= IDLE;
        end
        RMW_WR: begin
          resp_valid_r <= 1'b1;
          state_r      <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state_r == IDLE);
  assign bus.resp_valid   = resp_valid_r;
  assign bus.resp_err     = resp_err_r;
  assign bus.resp_rdata   = resp_rdata_r;
  assign bus.mem_r_enable = mem_r_enable_s;
  assign bus.mem_w_enable = mem_w_enable_s;
  assign bus.mem_address  = mem_address_s;
  assign bus.mem_wr_data  = mem_wr_data_s;

endmodule
